dbus_interconnect: RTL and testbench

//  Parametrised data-bus interconnect between the core's memory stage and NUM_SLAVES peripherals.
//  It replaces the fixed dmem/uart decode and output mux.

---
 rtl/dbus_interconnect_pkg.sv | 26 ++
 rtl/dbus_interconnect_if.sv | 37 +++
 rtl/dbus_interconnect_addr_decode.sv | 30 +++
 rtl/dbus_interconnect.sv | 160 ++++++++++++++++
 tb/tb_dbus_interconnect.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dbus_interconnect_pkg.sv
// Shared types and helpers for the data-bus interconnect.
// Imported by the decoder and the top.
package dbus_pkg;

    localparam int DBUS_DW = 32;
    localparam int DBUS_AW = 32;
    localparam int BE_W    = DBUS_DW / 8;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } dbus_state_t;

    typedef struct packed {
        logic               we;
        logic [BE_W-1:0]    be;
        logic [DBUS_AW-1:0] addr;
        logic [DBUS_DW-1:0] wdata;
    } dbus_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dbus_interconnect_if.sv
// Bus bundle between core memory stage, interconnect and slaves.
// master: interconnect's view of the core; slave: its view of peripherals.
interface dbus_interconnect_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4
);

    logic                             m_req;
    logic                             m_we;
    logic [DATA_WIDTH/8-1:0]          m_be;
    logic [ADDR_WIDTH-1:0]            m_addr;
    logic [DATA_WIDTH-1:0]            m_wdata;
    logic [DATA_WIDTH-1:0]            m_rdata;
    logic                             m_ready;
    logic                             m_err;
    logic                             m_stall;

    logic [NUM_SLAVES-1:0]            s_req;
    logic                             s_we;
    logic [DATA_WIDTH/8-1:0]          s_be;
    logic [ADDR_WIDTH-1:0]            s_addr;
    logic [DATA_WIDTH-1:0]            s_wdata;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata;
    logic [NUM_SLAVES-1:0]            s_ready;

    modport master (
        input  m_req, m_we, m_be, m_addr, m_wdata,
        output m_rdata, m_ready, m_err, m_stall
    );

    modport slave (
        output s_req, s_we, s_be, s_addr, s_wdata,
        input  s_rdata, s_ready
    );

endinterface

// File: rtl/dbus_interconnect_addr_decode.sv
// Address decoder: first (lowest-index) base/mask match wins.
// Purely combinational.
module dbus_addr_decode
    import dbus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SLAVES = 4,
    parameter int IW         = idx_w(NUM_SLAVES)
) (
    input  logic [ADDR_WIDTH-1:0]            addr,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] base,
    input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] mask,
    output logic                             hit,
    output logic [IW-1:0]                    idx
);

    // scan high to low so the lowest matching index is left standing
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & mask[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                base[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/dbus_interconnect.sv
// Data-bus interconnect: decode, slave handshake, timeout, read mux.
// A transaction always runs IDLE -> (ACTIVE) -> DONE -> IDLE.
module dbus_interconnect
    import dbus_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
    input logic                  clk,
    input logic                  reset,
    dbus_interconnect_if.master  mst,
    dbus_interconnect_if.slave   slv
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int IW = idx_w(NUM_SLAVES);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef struct packed {
        logic                  we;
        logic [BW-1:0]         be;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } req_t;

    dbus_state_t           state;
    dbus_state_t           nxt;
    req_t                  req_q;
    logic [IW-1:0]         idx_q;
    logic [CW-1:0]         cnt_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  hit;
    logic [IW-1:0]         idx;
    logic                  sel_ready;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  accept;
    logic                  miss;
    logic                  fin_ok;
    logic                  fin_to;
    logic [NUM_SLAVES-1:0] s_req_d;

    dbus_addr_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_SLAVES (NUM_SLAVES),
        .IW         (IW)
    ) u_decode (
        .addr (mst.m_addr),
        .base (SLAVE_BASE),
        .mask (SLAVE_MASK),
        .hit  (hit),
        .idx  (idx)
    );

    assign sel_ready = slv.s_ready[idx_q];
    assign sel_rdata = slv.s_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH];

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // next state and the one-cycle events that drive the datapath
    always_comb begin
        nxt    = state;
        accept = 1'b0;
        miss   = 1'b0;
        fin_ok = 1'b0;
        fin_to = 1'b0;
        unique case (state)
            IDLE: begin
                if (mst.m_req) begin
                    if (hit) begin
                        accept = 1'b1;
                        nxt    = ACTIVE;
                    end else begin
                        miss = 1'b1;
                        nxt  = DONE;
                    end
                end
            end
            ACTIVE: begin
                if (sel_ready) begin
                    fin_ok = 1'b1;
                    nxt    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fin_to = 1'b1;
                    nxt    = DONE;
                end
            end
            DONE: begin
                nxt = IDLE;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // request latch, saturating timeout counter and response register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                req_q.we    <= mst.m_we;
                req_q.be    <= mst.m_be;
                req_q.addr  <= mst.m_addr;
                req_q.wdata <= mst.m_wdata;
                idx_q       <= idx;
                cnt_q       <= '0;
            end
            if (state == ACTIVE && !sel_ready && cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (miss || fin_to) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end
            if (fin_ok) begin
                rdata_q <= req_q.we ? '0 : sel_rdata;
                err_q   <= 1'b0;
            end
        end
    end

    // one-hot slave request, only while ACTIVE
    always_comb begin
        s_req_d = '0;
        if (state == ACTIVE) begin
            s_req_d[idx_q] = 1'b1;
        end
    end

    assign slv.s_req   = s_req_d;
    assign slv.s_we    = req_q.we;
    assign slv.s_be    = req_q.be;
    assign slv.s_addr  = req_q.addr;
    assign slv.s_wdata = req_q.wdata;

    assign mst.m_ready = (state == DONE);
    assign mst.m_err   = err_q & (state == DONE);
    assign mst.m_rdata = rdata_q;
    assign mst.m_stall = mst.m_req & ~mst.m_ready;

endmodule

// File: tb/tb_dbus_interconnect.sv
// Directed bench for dbus_interconnect with a response scoreboard.
// Four slaves, timeout of eight ACTIVE cycles.
module tb_dbus_interconnect;

    localparam int NS = 4;
    localparam int TO = 8;
    localparam logic [NS*32-1:0] BASE = {
        32'h8000_0200, 32'h8000_0100, 32'h8000_0000, 32'h0000_0000
    };
    localparam logic [NS*32-1:0] MASK = {
        32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000
    };

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    dbus_interconnect_if #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_SLAVES (NS)
    ) bus ();

    dbus_interconnect #(
        .DATA_WIDTH     (32),
        .ADDR_WIDTH     (32),
        .NUM_SLAVES     (NS),
        .TIMEOUT_CYCLES (TO),
        .SLAVE_BASE     (BASE),
        .SLAVE_MASK     (MASK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .mst   (bus),
        .slv   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [32:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_chk(input string tag);
        step();
        chk({tag, "_ready_drop"}, bus.m_ready, 1'b0);
        chk({tag, "_sreq_idle"}, bus.s_req, 4'b0);
    endtask

    task automatic txn(
        input string       tag,
        input logic [31:0] addr,
        input logic        we,
        input logic [3:0]  be,
        input logic [31:0] wd,
        input int          sel,
        input int          waitc,
        input logic [31:0] rd,
        input bit          noise,
        input bit          drop,
        input bit          hold,
        input int          exp_lat,
        input int          exp_act,
        input logic        exp_err
    );
        int          lat;
        int          act;
        bit          seen;
        bit          bad_oh;
        bit          bad_fld;
        bit          bad_stall;
        logic [3:0]  oh;
        logic [31:0] exp_rd;
        logic [32:0] item;
        lat       = 0;
        act       = 0;
        seen      = 1'b0;
        bad_oh    = 1'b0;
        bad_fld   = 1'b0;
        bad_stall = 1'b0;
        oh        = (sel >= 0) ? 4'(1 << sel) : 4'b0;
        exp_rd    = (exp_err || we) ? 32'h0 : rd;
        sb.push_back({exp_err, exp_rd});
        bus.m_req   = 1'b1;
        bus.m_we    = we;
        bus.m_be    = be;
        bus.m_addr  = addr;
        bus.m_wdata = wd;
        if (sel >= 0) bus.s_rdata[sel*32 +: 32] = rd;
        bus.s_ready = noise ? 4'hF : 4'h0;
        #1;
        if (!bus.m_ready) chk({tag, "_stall_start"}, bus.m_stall, 1'b1);
        for (int c = 0; c < 40 && !seen; c++) begin
            step();
            lat++;
            if (bus.m_ready) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
                    item = '0;
                end else begin
                    item = sb.pop_front();
                end
                chk({tag, "_err"}, bus.m_err, item[32]);
                chk({tag, "_rdata"}, bus.m_rdata, item[31:0]);
                chk({tag, "_stall_end"}, bus.m_stall, 1'b0);
                chk({tag, "_sreq_done"}, bus.s_req, 4'b0);
                if (!hold) bus.m_req = 1'b0;
                bus.s_ready = 4'h0;
            end else begin
                if (!drop && bus.m_stall !== 1'b1) bad_stall = 1'b1;
                if (bus.s_req != 4'b0) begin
                    act++;
                    if (bus.s_req !== oh) bad_oh = 1'b1;
                    if (bus.s_addr !== addr || bus.s_we !== we ||
                        bus.s_be !== be || bus.s_wdata !== wd)
                        bad_fld = 1'b1;
                    if (drop && act == 1) begin
                        bus.m_req   = 1'b0;
                        bus.m_addr  = ~addr;
                        bus.m_wdata = ~wd;
                        bus.m_we    = ~we;
                        bus.m_be    = ~be;
                    end
                    bus.s_ready = noise ? ~oh : 4'h0;
                    if (act > waitc) bus.s_ready = bus.s_ready | oh;
                end else begin
                    bus.s_ready = noise ? 4'hF : 4'h0;
                end
            end
        end
        chk({tag, "_completed"}, 32'(seen), 32'd1);
        if (!seen) sb.delete();
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_active_cycles"}, 32'(act), 32'(exp_act));
        chk({tag, "_onehot"}, 32'(bad_oh), 32'd0);
        chk({tag, "_fields_stable"}, 32'(bad_fld), 32'd0);
        chk({tag, "_stall_hold"}, 32'(bad_stall), 32'd0);
    endtask

    initial begin
        bus.m_req   = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_be    = 4'h0;
        bus.m_addr  = 32'h0;
        bus.m_wdata = 32'h0;
        bus.s_ready = 4'h0;
        for (int i = 0; i < NS; i++) bus.s_rdata[i*32 +: 32] = 32'hA0A0_0000 + i;

        step();
        step();
        chk("rst_ready", bus.m_ready, 1'b0);
        chk("rst_err", bus.m_err, 1'b0);
        chk("rst_rdata", bus.m_rdata, 32'h0);
        chk("rst_sreq", bus.s_req, 4'b0);
        chk("rst_saddr", bus.s_addr, 32'h0);
        chk("rst_swdata", bus.s_wdata, 32'h0);
        chk("rst_sbe", bus.s_be, 4'h0);
        chk("rst_swe", bus.s_we, 1'b0);
        chk("rst_stall", bus.m_stall, 1'b0);
        reset = 1'b1;
        step();

        txn("t1", 32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 0, 32'hDEAD_BEEF,
            1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
        idle_chk("t1");

        txn("t2", 32'h8000_0104, 1'b1, 4'b0001, 32'h55, 2, 3, 32'h1234_5678,
            1'b0, 1'b0, 1'b0, 5, 4, 1'b0);
        idle_chk("t2");

        txn("t3", 32'h4000_0000, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0,
            1'b0, 1'b0, 1'b0, 1, 0, 1'b1);
        idle_chk("t3");

        txn("t4", 32'h8000_0200, 1'b0, 4'hF, 32'h0, 3, 1000, 32'hCAFE_0003,
            1'b0, 1'b0, 1'b0, 9, 8, 1'b1);
        idle_chk("t4");

        txn("t4b", 32'h8000_0200, 1'b0, 4'hF, 32'h0, 3, 7, 32'hCAFE_0003,
            1'b0, 1'b0, 1'b0, 9, 8, 1'b0);
        idle_chk("t4b");

        txn("t5a", 32'h8000_0010, 1'b0, 4'hF, 32'h0, 1, 1, 32'h1111_0001,
            1'b1, 1'b0, 1'b1, 3, 2, 1'b0);
        txn("t5b", 32'h0000_0020, 1'b0, 4'hF, 32'h0, 0, 1, 32'h2222_0000,
            1'b1, 1'b0, 1'b0, 4, 2, 1'b0);
        idle_chk("t5");

        txn("t7", 32'h8000_0204, 1'b1, 4'b0000, 32'hA5A5_A5A5, 3, 2, 32'h33,
            1'b0, 1'b1, 1'b0, 4, 3, 1'b0);
        idle_chk("t7");

        bus.m_req  = 1'b1;
        bus.m_we   = 1'b0;
        bus.m_be   = 4'hF;
        bus.m_addr = 32'h8000_0200;
        step();
        step();
        chk("t6_sreq_active", bus.s_req, 4'b1000);
        #1;
        reset = 1'b0;
        #1;
        chk("t6_sreq_rst", bus.s_req, 4'b0);
        chk("t6_ready_rst", bus.m_ready, 1'b0);
        chk("t6_err_rst", bus.m_err, 1'b0);
        chk("t6_rdata_rst", bus.m_rdata, 32'h0);
        chk("t6_saddr_rst", bus.s_addr, 32'h0);
        bus.m_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("t6_idle_after", bus.s_req, 4'b0);

        txn("t6post", 32'h0000_0014, 1'b0, 4'hF, 32'h0, 0, 0, 32'hBEEF_0000,
            1'b0, 1'b0, 1'b0, 2, 1, 1'b0);
        idle_chk("t6post");

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
